// File: rtl/i2c_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_pkg : state codes and shared constants for the byte-level I2C master
// Revision: 1.0
// ----------------------------------------------------------------------------
package i2c_pkg;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_ADDR_W = 4'd2;
  localparam logic [3:0] S_ACK_A  = 4'd3;
  localparam logic [3:0] S_REG    = 4'd4;
  localparam logic [3:0] S_ACK_R  = 4'd5;
  localparam logic [3:0] S_WDATA  = 4'd6;
  localparam logic [3:0] S_ACK_D  = 4'd7;
  localparam logic [3:0] S_RSTART = 4'd8;
  localparam logic [3:0] S_ADDR_R = 4'd9;
  localparam logic [3:0] S_ACK_AR = 4'd10;
  localparam logic [3:0] S_RDATA  = 4'd11;
  localparam logic [3:0] S_MNACK  = 4'd12;
  localparam logic [3:0] S_STOP   = 4'd13;

  localparam int WR_SLOTS = 29;
  localparam int RD_SLOTS = 39;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_tick_gen : quarter-bit strobe and quarter index, held cleared while idle
// Revision: 1.0
// ----------------------------------------------------------------------------
module i2c_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic       tick_o,
  output logic [1:0] quarter_o
);

  localparam int              CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q;
  logic [1:0]    qtr_q;

  assign tick_o    = en_i && (div_q == DIV_LAST);
  assign quarter_o = qtr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      qtr_q <= 2'd0;
    end else if (!en_i) begin
      div_q <= '0;
      qtr_q <= 2'd0;
    end else if (tick_o) begin
      div_q <= '0;
      qtr_q <= qtr_q + 2'd1;
    end else begin
      div_q <= div_q + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_master : register-addressed single-byte I2C write/read master
// Revision: 1.0
// ----------------------------------------------------------------------------
module i2c_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  output logic       sda_out,
  input  logic       sda_in
);

  import i2c_pkg::*;

  logic [3:0] state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d, wdat_q, wdat_d;
  logic [7:0] shift_q, shift_d, rdata_q, rdata_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic       scl_q, scl_d, sda_q, sda_d;
  logic       tick;
  logic [1:0] qtr;
  logic       is_ack, is_byte;
  logic [7:0] tx_byte;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (busy_q),
    .tick_o    (tick),
    .quarter_o (qtr)
  );

  always_comb begin
    is_ack  = (state_q inside {S_ACK_A, S_ACK_R, S_ACK_D, S_ACK_AR});
    is_byte = (state_q inside {S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RDATA});
    case (state_q)
      S_ADDR_W: tx_byte = {dev_q, 1'b0};
      S_REG:    tx_byte = reg_q;
      S_WDATA:  tx_byte = wdat_q;
      S_ADDR_R: tx_byte = {dev_q, 1'b1};
      default:  tx_byte = 8'hFF;
    endcase
  end

  // Line levels per quarter; they are registered so the pins never glitch.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
      S_START: begin
        scl_d = (qtr != 2'd3);
        sda_d = (qtr < 2'd2);
      end
      S_RSTART: begin
        scl_d = (qtr == 2'd1) || (qtr == 2'd2);
        sda_d = (qtr < 2'd2);
      end
      S_STOP: begin
        scl_d = (qtr != 2'd0);
        sda_d = (qtr >= 2'd2);
      end
      default: begin
        scl_d = (qtr == 2'd1) || (qtr == 2'd2);
        sda_d = tx_byte[bit_q];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdat_d  = wdat_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      // The done cycle is already IDLE; a start seen then is deliberately skipped.
      if (start && !done_q) begin
        rw_d    = rw;
        dev_d   = dev_addr;
        reg_d   = reg_addr;
        wdat_d  = wdata;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        bit_d   = 3'd7;
        state_d = S_START;
      end
    end else if (tick) begin
      if (qtr == 2'd2) begin
        if (is_ack && sda_in) err_d = 1'b1;
        if (state_q == S_RDATA) shift_d = {shift_q[6:0], sda_in};
      end
      if (qtr == 2'd3) begin
        if (is_byte) bit_d = bit_q - 3'd1;
        case (state_q)
          S_START:  state_d = S_ADDR_W;
          S_ADDR_W: if (bit_q == 3'd0) state_d = S_ACK_A;
          S_ACK_A:  state_d = err_q ? S_STOP : S_REG;
          S_REG:    if (bit_q == 3'd0) state_d = S_ACK_R;
          S_ACK_R:  state_d = err_q ? S_STOP : ((rw_q == RW_READ) ? S_RSTART : S_WDATA);
          S_WDATA:  if (bit_q == 3'd0) state_d = S_ACK_D;
          S_ACK_D:  state_d = S_STOP;
          S_RSTART: state_d = S_ADDR_R;
          S_ADDR_R: if (bit_q == 3'd0) state_d = S_ACK_AR;
          S_ACK_AR: state_d = err_q ? S_STOP : S_RDATA;
          S_RDATA: begin
            if (bit_q == 3'd0) begin
              rdata_d = shift_q;
              state_d = S_MNACK;
            end
          end
          S_MNACK:  state_d = S_STOP;
          S_STOP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bit_q   <= 3'd7;
      rw_q    <= RW_WRITE;
      dev_q   <= 7'd0;
      reg_q   <= 8'd0;
      wdat_q  <= 8'd0;
      shift_q <= 8'd0;
      rdata_q <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdat_q  <= wdat_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = err_q;
  assign scl     = scl_q;
  assign sda_out = sda_q;

endmodule
`default_nettype wire
